hc595_rx: RTL and testbench
===========================

HC595_RX -- requirements
Module: hc595_rx

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, meaning the input synchronizer depth (at least 2).
REQ-002 SHALL provide parameter FRAME_BITS, default 16, meaning the number of bits per latched frame.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port sclk_in, input, 1 bit, the 74HC595 SCK line (asynchronous).
REQ-006 SHALL have port rclk_in, input, 1 bit, the 74HC595 RCK line (asynchronous).
REQ-007 SHALL have port sdio_in, input, 1 bit, the 74HC595 SER line (asynchronous).
REQ-008 SHALL have port frame_valid, output, 1 bit, a one-cycle pulse when a decoded frame is presented.
REQ-009 SHALL have port frame_err, output, 1 bit, a one-cycle pulse coincident with frame_valid when the frame is malformed.
REQ-010 SHALL have port digit_idx, output, 3 bits, the selected digit (0 = seg1 .. 7 = seg8).
REQ-011 SHALL have port seg_raw, output, 8 bits, the latched active-low pattern {dp,g,f,e,d,c,b,a}.
REQ-012 SHALL have port code, output, 5 bits, the decoded display code.
REQ-013 SHALL have port dot, output, 1 bit, the decimal point lit (1 = lit).
REQ-014 SHALL have port disp_codes, output, 40 bits, the mirror of all 8 digit codes; seg1 is in bits [4:0].
REQ-015 SHALL have port disp_dots, output, 8 bits, the mirror of the 8 dot states; seg1 is in bit 0.

Function
REQ-016 SHALL synchronize sclk_in, rclk_in and sdio_in through SYNC_STAGES flops each, then detect rising edges with one further register stage.
REQ-017 SHALL require each input high and low time to be at least 2 clk cycles; behaviour for shorter pulses is undefined.
REQ-018 SHALL, on each detected sclk rise, shift the synchronized sdio into bit 0 of a FRAME_BITS shift register (MSB first on the wire) and increment a 5-bit bit counter that saturates at 31.
REQ-019 SHALL, on each detected rclk rise, latch the shift register, clear the bit counter, and run the decode cycle on the following clk cycle.
REQ-020 SHALL, when sclk and rclk rises are detected in the same cycle, shift first, so the latched frame includes the new bit and the count includes it.
REQ-021 SHALL assign frame bits as follows: [15:8] is seg_raw and [7:0] is the active-high one-hot digit select.
REQ-022 SHALL decode seg_raw[6:0] as follows: digit glyphs 0-9 give codes 0-9; all segments off gives 16; pattern "r" (e,g on) gives 17; pattern "=" (d,g on) gives 18; any other pattern gives 31.
REQ-023 SHALL set dot = ~seg_raw[7].
REQ-024 SHALL assert frame_err when the bit count at latch is not equal to FRAME_BITS, or when the digit select is not exactly one-hot.
REQ-025 SHALL, when frame_err is asserted, leave digit_idx, disp_codes and disp_dots unchanged, while still updating seg_raw, code and dot.
REQ-026 SHALL, for a valid frame, write code and dot into the disp_codes and disp_dots slot given by digit_idx.
REQ-027 SHALL pulse frame_valid exactly SYNC_STAGES+2 clk cycles after the first clk edge that samples rclk_in high; frame_valid is never asserted on two consecutive cycles.
REQ-028 SHALL treat an rclk rise with zero bits shifted as an error frame (count 0).
REQ-029 SHALL hold all outputs stable between frame_valid pulses.

Reset
REQ-030 SHALL clear synchronizers, edge registers, shift register, bit counter, frame_valid, frame_err, digit_idx, seg_raw (to 8'hFF), dot and disp_dots to 0.
REQ-031 SHALL reset code to 16 and every disp_codes slot to 16.
REQ-032 SHALL abort and discard any partially shifted frame when rst is asserted mid-frame; the first frame after reset requires a full FRAME_BITS shift.

Structure
REQ-033 SHALL place the following in a shared package: the segment glyph constants, the display code constants (0-9, 16 blank, 17 r, 18 =, 31 unknown) and the glyph-to-code decode function; the led_segment driver uses the same package.
REQ-034 SHALL implement the synchronizer plus edge detector as one sub-module, sync_edge, instantiated three times.

Verification
REQ-035 SHALL verify: shift 16'hC001 (glyph 0, seg1) then rclk -> frame_valid after 4 clk, code=0, digit_idx=0, dot=0, disp_codes[4:0]=0.
REQ-036 SHALL verify: shift 16'h2480 (glyph 2 with dp, seg8) -> code=2, dot=1, digit_idx=7, disp_dots[7]=1.
REQ-037 SHALL verify: shift 15 bits then rclk -> frame_err=1 and disp_codes unchanged (all 16 after reset).
REQ-038 SHALL verify: digit select 8'h03 -> frame_err=1 and digit_idx unchanged.
REQ-039 SHALL verify: sclk and rclk rising in the same sample on bit 16 -> a valid frame containing that bit.
REQ-040 SHALL verify: rst asserted after 8 bits, then a full 16'hFF04 frame -> code=16, digit_idx=2, no error.

Source files
------------

// File: rtl/hc595_pkg.sv
// Shared 7-segment definitions: glyph patterns (active-high {g,f,e,d,c,b,a}),
// display codes and the pattern-to-code decoder used by receiver and driver.
package hc595_pkg;

    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;
    localparam logic [6:0] GLYPH_R     = 7'h50;
    localparam logic [6:0] GLYPH_EQ    = 7'h48;

    localparam logic [4:0] CODE_BLANK   = 5'd16;
    localparam logic [4:0] CODE_R       = 5'd17;
    localparam logic [4:0] CODE_EQ      = 5'd18;
    localparam logic [4:0] CODE_UNKNOWN = 5'd31;

    // Input is the active-low pattern as it appears on the shift register.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg_n);
        logic [6:0] on;
        on = ~seg_n;
        case (on)
            GLYPH_0:     seg_decode = 5'd0;
            GLYPH_1:     seg_decode = 5'd1;
            GLYPH_2:     seg_decode = 5'd2;
            GLYPH_3:     seg_decode = 5'd3;
            GLYPH_4:     seg_decode = 5'd4;
            GLYPH_5:     seg_decode = 5'd5;
            GLYPH_6:     seg_decode = 5'd6;
            GLYPH_7:     seg_decode = 5'd7;
            GLYPH_8:     seg_decode = 5'd8;
            GLYPH_9:     seg_decode = 5'd9;
            GLYPH_BLANK: seg_decode = CODE_BLANK;
            GLYPH_R:     seg_decode = CODE_R;
            GLYPH_EQ:    seg_decode = CODE_EQ;
            default:     seg_decode = CODE_UNKNOWN;
        endcase
    endfunction

    function automatic logic is_onehot(input logic [7:0] sel);
        return (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
    endfunction

    // Only meaningful for a one-hot select.
    function automatic logic [2:0] onehot_index(input logic [7:0] sel);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer followed by a registered rising-edge pulse.
// level is delayed to line up with rise so data sampled on rise is coherent.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;
    logic              rise_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
            prev_reg <= sync_reg[STAGES-1];
            rise_reg <= sync_reg[STAGES-1] & ~prev_reg;
        end
    end

    assign level = prev_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/hc595_rx.sv
// Sniffs a 74HC595-driven 8-digit LED display bus and decodes each latched
// frame into a digit code, keeping a mirror of every digit's contents.
module hc595_rx
    import hc595_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk_in,
    input  logic        rclk_in,
    input  logic        sdio_in,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [2:0]  digit_idx,
    output logic [7:0]  seg_raw,
    output logic [4:0]  code,
    output logic        dot,
    output logic [39:0] disp_codes,
    output logic [7:0]  disp_dots
);

    logic [2:0] din_vec;
    logic [2:0] level_vec;
    logic [2:0] rise_vec;

    assign din_vec = {sdio_in, rclk_in, sclk_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
                .clk   (clk),
                .rst   (rst),
                .din   (din_vec[gi]),
                .level (level_vec[gi]),
                .rise  (rise_vec[gi])
            );
        end
    endgenerate

    logic sclk_rise, rclk_rise, sdio_level;
    assign sclk_rise  = rise_vec[0];
    assign rclk_rise  = rise_vec[1];
    assign sdio_level = level_vec[2];

    logic unused_sync;
    assign unused_sync = ^{level_vec[1:0], rise_vec[2]};

    logic [FRAME_BITS-1:0] shift_reg, shift_next, frame_reg;
    logic [4:0]            bit_cnt_reg, cnt_next, frame_cnt_reg;
    logic                  decode_reg;

    // A simultaneous sclk rise is folded in before the latch sees the frame.
    always_comb begin
        shift_next = shift_reg;
        cnt_next   = bit_cnt_reg;
        if (sclk_rise) begin
            shift_next = {shift_reg[FRAME_BITS-2:0], sdio_level};
            cnt_next   = (bit_cnt_reg == 5'd31) ? 5'd31 : bit_cnt_reg + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg     <= '0;
            bit_cnt_reg   <= 5'd0;
            frame_reg     <= '0;
            frame_cnt_reg <= 5'd0;
            decode_reg    <= 1'b0;
        end else begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= rclk_rise ? 5'd0 : cnt_next;
            decode_reg  <= rclk_rise;
            if (rclk_rise) begin
                frame_reg     <= shift_next;
                frame_cnt_reg <= cnt_next;
            end
        end
    end

    logic [7:0] seg_w, sel_w;
    logic [4:0] code_w;
    logic [2:0] idx_w;
    logic       err_w;

    assign seg_w  = frame_reg[15:8];
    assign sel_w  = frame_reg[7:0];
    assign code_w = seg_decode(seg_w[6:0]);
    assign idx_w  = onehot_index(sel_w);
    assign err_w  = (frame_cnt_reg != 5'(FRAME_BITS)) || !is_onehot(sel_w);

    logic       frame_valid_reg, frame_err_reg, dot_reg;
    logic [2:0] digit_idx_reg;
    logic [7:0] seg_raw_reg;
    logic [4:0] code_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            digit_idx_reg   <= 3'd0;
            seg_raw_reg     <= 8'hFF;
            code_reg        <= CODE_BLANK;
            dot_reg         <= 1'b0;
        end else begin
            frame_valid_reg <= decode_reg;
            frame_err_reg   <= decode_reg & err_w;
            if (decode_reg) begin
                seg_raw_reg <= seg_w;
                code_reg    <= code_w;
                dot_reg     <= ~seg_w[7];
                if (!err_w) digit_idx_reg <= idx_w;
            end
        end
    end

    logic [4:0] slot_code_reg [8];
    logic [7:0] slot_dot_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_code_reg[gi] <= CODE_BLANK;
                    slot_dot_reg[gi]  <= 1'b0;
                end else if (decode_reg && !err_w && idx_w == 3'(gi)) begin
                    slot_code_reg[gi] <= code_w;
                    slot_dot_reg[gi]  <= ~seg_w[7];
                end
            end
            assign disp_codes[gi*5 +: 5] = slot_code_reg[gi];
        end
    endgenerate

    assign frame_valid = frame_valid_reg;
    assign frame_err   = frame_err_reg;
    assign digit_idx   = digit_idx_reg;
    assign seg_raw     = seg_raw_reg;
    assign code        = code_reg;
    assign dot         = dot_reg;
    assign disp_dots   = slot_dot_reg;

endmodule

// File: tb/tb_hc595_rx.sv
// Scoreboard bench for hc595_rx: stimulus pushes expected frames from a
// bit-level reference model, a monitor pops and compares on frame_valid.
module tb_hc595_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk_in = 1'b0, rclk_in = 1'b0, sdio_in = 1'b0;
    logic        frame_valid, frame_err, dot;
    logic [2:0]  digit_idx;
    logic [7:0]  seg_raw, disp_dots;
    logic [4:0]  code;
    logic [39:0] disp_codes;

    hc595_rx #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk_in    (sclk_in),
        .rclk_in    (rclk_in),
        .sdio_in    (sdio_in),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .digit_idx  (digit_idx),
        .seg_raw    (seg_raw),
        .code       (code),
        .dot        (dot),
        .disp_codes (disp_codes),
        .disp_dots  (disp_dots)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [7:0]  seg;
        logic [4:0]  code;
        logic        dot;
        logic [2:0]  digit;
        logic [39:0] codes;
        logic [7:0]  dots;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [15:0] m_shift;
    int          m_cnt;
    logic [4:0]  m_codes [8];
    logic [7:0]  m_dots;
    logic [2:0]  m_digit;

    logic [6:0] glyph_tbl [13] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                                   7'h07, 7'h7F, 7'h6F, 7'h00, 7'h50, 7'h48};
    logic [4:0] code_tbl  [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                                   5'd7, 5'd8, 5'd9, 5'd16, 5'd17, 5'd18};

    function automatic logic [4:0] ref_code(input logic [6:0] on);
        logic [4:0] c;
        c = 5'd31;
        for (int i = 0; i < 13; i++) if (glyph_tbl[i] == on) c = code_tbl[i];
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_shift = 16'h0;
        m_cnt   = 0;
        m_dots  = 8'h0;
        m_digit = 3'd0;
        for (int i = 0; i < 8; i++) m_codes[i] = 5'd16;
    endtask

    task automatic model_shift(input logic b);
        m_shift = {m_shift[14:0], b};
        m_cnt   = (m_cnt >= 31) ? 31 : m_cnt + 1;
    endtask

    // Called on the negedge where rclk_in is driven high.
    task automatic push_expect();
        exp_t e;
        logic [7:0] seg, sel;
        int ones;
        seg = m_shift[15:8];
        sel = m_shift[7:0];
        ones = $countones(sel);
        e.cyc  = cyc + 5;
        e.err  = (m_cnt != 16) || (ones != 1);
        e.seg  = seg;
        e.code = ref_code(~seg[6:0]);
        e.dot  = ~seg[7];
        if (!e.err) begin
            for (int i = 0; i < 8; i++) if (sel[i]) m_digit = 3'(i);
            m_codes[m_digit] = e.code;
            m_dots[m_digit]  = e.dot;
        end
        e.digit = m_digit;
        for (int i = 0; i < 8; i++) e.codes[i*5 +: 5] = m_codes[i];
        e.dots = m_dots;
        m_cnt = 0;
        sb.push_back(e);
    endtask

    task automatic shift_bit(input logic b);
        sdio_in = b;
        tick(2);
        sclk_in = 1'b1;
        model_shift(b);
        tick(2);
        sclk_in = 1'b0;
        tick(2);
    endtask

    task automatic latch(input logic with_bit, input logic b);
        if (with_bit) begin
            sdio_in = b;
            tick(2);
            sclk_in = 1'b1;
            model_shift(b);
        end
        rclk_in = 1'b1;
        push_expect();
        tick(2);
        sclk_in = 1'b0;
        rclk_in = 1'b0;
        tick(2);
    endtask

    task automatic send_frame(input logic [31:0] val, input int nbits, input logic same);
        logic [31:0] v;
        v = val;
        if (nbits == 0) begin
            latch(1'b0, 1'b0);
        end else begin
            for (int i = nbits - 1; i >= 1; i--) shift_bit(v[i]);
            if (same) latch(1'b1, v[0]);
            else begin
                shift_bit(v[0]);
                latch(1'b0, 1'b0);
            end
        end
    endtask

    task automatic wait_flush();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        chk("flush_pending", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sclk_in = 1'b0;
        rclk_in = 1'b0;
        sdio_in = 1'b0;
        tick(3);
        rst = 1'b0;
        model_reset();
        tick(2);
    endtask

    // Monitor: compares every presented frame against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) begin
                if (sb.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_frame actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("frame cyc=%0d err=%0b seg=%02h code=%0d dot=%0b digit=%0d",
                             cyc, frame_err, seg_raw, code, dot, digit_idx);
                    chk("valid_latency", 64'(cyc), 64'(e.cyc));
                    chk("frame_err", 64'(frame_err), 64'(e.err));
                    chk("seg_raw", 64'(seg_raw), 64'(e.seg));
                    chk("code", 64'(code), 64'(e.code));
                    chk("dot", 64'(dot), 64'(e.dot));
                    chk("digit_idx", 64'(digit_idx), 64'(e.digit));
                    chk("disp_codes", 64'(disp_codes), 64'(e.codes));
                    chk("disp_dots", 64'(disp_dots), 64'(e.dots));
                end
            end else if (frame_err) begin
                errors++;
                checks++;
                $display("FAIL err_without_valid actual=1 expected=0 (cycle %0d)", cyc);
            end
        end
    end

    initial begin
        logic [7:0]  seg, sel;
        logic [31:0] val;
        int          nb;
        model_reset();
        tick(1);
        do_reset();

        chk("rst_frame_valid", 64'(frame_valid), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_seg_raw", 64'(seg_raw), 64'hFF);
        chk("rst_code", 64'(code), 64'd16);
        chk("rst_dot", 64'(dot), 64'd0);
        chk("rst_digit_idx", 64'(digit_idx), 64'd0);
        chk("rst_disp_codes", 64'(disp_codes), 64'h8421084210);
        chk("rst_disp_dots", 64'(disp_dots), 64'd0);

        send_frame(32'h4001, 15, 1'b0);   // short frame -> error, mirror untouched
        send_frame(32'hC001, 16, 1'b0);   // glyph 0 on seg1
        send_frame(32'h2480, 16, 1'b0);   // glyph 2 + dp on seg8
        send_frame(32'hF903, 16, 1'b0);   // two digits selected -> error
        send_frame(32'hB010, 16, 1'b1);   // last bit shares the rclk rise
        send_frame(32'h0, 0, 1'b0);       // latch with nothing shifted
        wait_flush();

        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1);
        shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b0);
        do_reset();
        send_frame(32'hFF04, 16, 1'b0);   // blank on seg3 after mid-frame reset
        wait_flush();
        chk("after_rst_digit", 64'(digit_idx), 64'd2);
        chk("after_rst_code", 64'(code), 64'd16);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) seg = 8'($urandom);
            else seg = {1'($urandom), ~glyph_tbl[$urandom_range(0, 12)]};
            if ($urandom_range(0, 5) == 0) sel = 8'($urandom);
            else sel = 8'h1 << $urandom_range(0, 7);
            val = {16'($urandom), seg, sel};
            nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 34)) : 16;
            send_frame(val, nb, 1'($urandom));
        end
        wait_flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
